// File: rtl/fetch_unit.sv
// Program counter and fetch sequencer for the 1024-entry instruction ROM.
// Start/ack handshake, four entry points, sequential/relative/absolute PC updates.
//
// state | meaning
// IDLE  | out of reset, waiting for Start
// ARMED | Start held high, program select being latched
// RUN   | fetching, PC advances each non-stalled cycle
// DONE  | halted, PC and retired count frozen until Start
module fetch_unit #(
  parameter int unsigned AW       = 10,
  parameter int unsigned OFFW     = 8,
  parameter int unsigned CNTW     = 16,
  parameter logic [AW-1:0] P0_START = 10'd0,
  parameter logic [AW-1:0] P1_START = 10'd256,
  parameter logic [AW-1:0] P2_START = 10'd512,
  parameter logic [AW-1:0] P3_START = 10'd768
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [1:0]      ProgSel,
  input  logic            Stall,
  input  logic            Halt,
  input  logic            BranchEn,
  input  logic            BranchAbs,
  input  logic [AW-1:0]   Target,
  input  logic [OFFW-1:0] Offset,
  output logic [AW-1:0]   InstAddress,
  output logic            Running,
  output logic            Done,
  output logic [CNTW-1:0] RetCount
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [1:0]      sel_q;
  logic [1:0]      sel_d;
  logic [AW-1:0]   pc_d;
  logic [CNTW-1:0] cnt_d;
  logic [AW-1:0]   entry_addr;
  logic [AW-1:0]   off_ext;
  logic [CNTW-1:0] cnt_inc;

  assign off_ext = {{(AW-OFFW){Offset[OFFW-1]}}, Offset};
  // Saturate rather than wrap so a long run never reports a small count.
  assign cnt_inc = (RetCount == {CNTW{1'b1}}) ? RetCount : RetCount + CNTW'(1);

  always_comb begin
    entry_addr = P0_START;
    case (sel_q)
      2'd0:    entry_addr = P0_START;
      2'd1:    entry_addr = P1_START;
      2'd2:    entry_addr = P2_START;
      2'd3:    entry_addr = P3_START;
      default: entry_addr = P0_START;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      sel_q       <= 2'd0;
      InstAddress <= '0;
      RetCount    <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      InstAddress <= pc_d;
      RetCount    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (Start) state_d = ARMED;
      ARMED:   if (!Start) state_d = RUN;
      RUN: begin
        if (Start)     state_d = ARMED;
        else if (Halt) state_d = DONE;
      end
      DONE:    if (Start) state_d = ARMED;
      default: state_d = IDLE;
    endcase
  end

  // Program select tracks ProgSel for as long as Start is held.
  assign sel_d = Start ? ProgSel : sel_q;

  always_comb begin
    pc_d  = InstAddress;
    cnt_d = RetCount;
    case (state_q)
      ARMED: begin
        if (!Start) begin
          pc_d  = entry_addr;
          cnt_d = '0;
        end
      end
      RUN: begin
        if (Start) begin
          pc_d = InstAddress;
        end else if (Halt) begin
          cnt_d = cnt_inc;
        end else if (Stall) begin
          pc_d = InstAddress;
        end else if (BranchEn) begin
          pc_d  = BranchAbs ? Target : InstAddress + off_ext;
          cnt_d = cnt_inc;
        end else begin
          pc_d  = InstAddress + AW'(1);
          cnt_d = cnt_inc;
        end
      end
      default: begin
        pc_d  = InstAddress;
        cnt_d = RetCount;
      end
    endcase
  end

  always_comb begin
    Running = (state_q == RUN);
    Done    = (state_q == DONE);
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus pushes expected outputs,
// a monitor pops and compares after each clock edge (and on async reset).
module tb_fetch_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] prog_sel;
  logic       stall;
  logic       halt;
  logic       branch_en;
  logic       branch_abs;
  logic [9:0] target;
  logic [7:0] offset;
  logic [9:0] inst_address;
  logic       running;
  logic       done;
  logic [15:0] ret_count;

  typedef struct {
    string       name;
    logic [9:0]  addr;
    logic        run;
    logic        dn;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  event async_ev;

  fetch_unit dut (
    .Clk         (clk),
    .Reset       (rst_n),
    .Start       (start),
    .ProgSel     (prog_sel),
    .Stall       (stall),
    .Halt        (halt),
    .BranchEn    (branch_en),
    .BranchAbs   (branch_abs),
    .Target      (target),
    .Offset      (offset),
    .InstAddress (inst_address),
    .Running     (running),
    .Done        (done),
    .RetCount    (ret_count)
  );

  always #5 clk = ~clk;

  task automatic compare_pop();
    exp_t e;
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    total++;
    if (inst_address !== e.addr || running !== e.run || done !== e.dn || ret_count !== e.cnt) begin
      bad++;
      $display("FAIL %s: got addr=%0d run=%0b done=%0b cnt=%0d, want addr=%0d run=%0b done=%0b cnt=%0d",
               e.name, inst_address, running, done, ret_count, e.addr, e.run, e.dn, e.cnt);
    end
  endtask

  always @(posedge clk) begin
    #1;
    compare_pop();
  end

  always @(async_ev) begin
    #1;
    compare_pop();
  end

  task automatic push(input string nm, input logic [9:0] a, input logic r, input logic d,
                      input logic [15:0] c);
    exp_t e;
    e.name = nm; e.addr = a; e.run = r; e.dn = d; e.cnt = c;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step_chk(input string nm, input logic [9:0] a, input logic r, input logic d,
                          input logic [15:0] c);
    push(nm, a, r, d, c);
    step();
  endtask

  task automatic jump_abs(input string nm, input logic [9:0] t, input logic [15:0] c);
    branch_en = 1'b1; branch_abs = 1'b1; target = t;
    step_chk(nm, t, 1'b1, 1'b0, c);
    branch_en = 1'b0; branch_abs = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; prog_sel = 2'd0; stall = 1'b0; halt = 1'b0;
    branch_en = 1'b0; branch_abs = 1'b0; target = '0; offset = '0;
    @(negedge clk);
    step_chk("reset", 10'd0, 1'b0, 1'b0, 16'd0);
    rst_n = 1'b1;

    // launch program 1
    start = 1'b1; prog_sel = 2'd1;
    for (int i = 0; i < 3; i++) step_chk("armed", 10'd0, 1'b0, 1'b0, 16'd0);
    start = 1'b0;
    step_chk("launch_p1", 10'd256, 1'b1, 1'b0, 16'd0);
    for (int i = 1; i <= 5; i++) step_chk("seq_inc", 10'(256 + i), 1'b1, 1'b0, 16'(i));

    // relative/absolute branches and wrap-around
    jump_abs("jump_300", 10'd300, 16'd6);
    branch_en = 1'b1; branch_abs = 1'b0; offset = 8'hFC;
    step_chk("rel_minus4", 10'd296, 1'b1, 1'b0, 16'd7);
    jump_abs("jump_1020", 10'd1020, 16'd8);
    step_chk("inc_1021", 10'd1021, 1'b1, 1'b0, 16'd9);
    step_chk("inc_1022", 10'd1022, 1'b1, 1'b0, 16'd10);
    step_chk("inc_1023", 10'd1023, 1'b1, 1'b0, 16'd11);
    step_chk("wrap_0", 10'd0, 1'b1, 1'b0, 16'd12);
    branch_en = 1'b1; offset = 8'hFC;
    step_chk("rel_wrap_down", 10'd1020, 1'b1, 1'b0, 16'd13);
    offset = 8'h08;
    step_chk("rel_wrap_up", 10'd4, 1'b1, 1'b0, 16'd14);
    branch_en = 1'b0;

    // stall beats branch
    jump_abs("jump_40", 10'd40, 16'd15);
    stall = 1'b1; branch_en = 1'b1; branch_abs = 1'b1; target = 10'd100;
    step_chk("stall_hold1", 10'd40, 1'b1, 1'b0, 16'd15);
    step_chk("stall_hold2", 10'd40, 1'b1, 1'b0, 16'd15);
    stall = 1'b0;
    step_chk("stall_release", 10'd100, 1'b1, 1'b0, 16'd16);
    branch_en = 1'b0; branch_abs = 1'b0;

    // halt, frozen DONE, re-arm into program 2
    jump_abs("jump_77", 10'd77, 16'd17);
    halt = 1'b1;
    step_chk("halt", 10'd77, 1'b0, 1'b1, 16'd18);
    halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      stall = i[0]; halt = i[1]; branch_en = 1'b1; branch_abs = i[2]; target = 10'd5; offset = 8'h10;
      step_chk("done_frozen", 10'd77, 1'b0, 1'b1, 16'd18);
    end
    stall = 1'b0; halt = 1'b0; branch_en = 1'b0; branch_abs = 1'b0;
    start = 1'b1; prog_sel = 2'd2;
    step_chk("done_rearm", 10'd77, 1'b0, 1'b0, 16'd18);
    start = 1'b0;
    step_chk("launch_p2", 10'd512, 1'b1, 1'b0, 16'd0);

    // abort mid-run, start outranks halt
    jump_abs("jump_500", 10'd500, 16'd1);
    start = 1'b1; prog_sel = 2'd3; halt = 1'b1;
    step_chk("abort", 10'd500, 1'b0, 1'b0, 16'd1);
    start = 1'b0; halt = 1'b0;
    step_chk("launch_p3", 10'd768, 1'b1, 1'b0, 16'd0);
    step_chk("inc_769", 10'd769, 1'b1, 1'b0, 16'd1);

    // retired counter saturation
    for (int i = 0; i < 65533; i++) step();
    step_chk("sat_reach", 10'd767, 1'b1, 1'b0, 16'hFFFF);
    step_chk("sat_hold", 10'd768, 1'b1, 1'b0, 16'hFFFF);

    // async reset mid-run, away from any clock edge
    #2;
    rst_n = 1'b0;
    push("async_reset", 10'd0, 1'b0, 1'b0, 16'd0);
    -> async_ev;
    #3;
    step();
    step();

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
